// File: rtl/ballot_sender.sv
// ballot_sender: collects one vote per judge, then streams the accepted votes
// in ascending judge order to the tally over a valid/ready handshake.
module ballot_sender #(
    parameter int unsigned NUM_JUDGES = 4,
    parameter int unsigned CODE_W     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              judge_cast,
    input  logic [1:0]        judge_id,
    input  logic [CODE_W-1:0] judge_vote,
    input  logic              close_poll,
    output logic              cast_ack,
    output logic              cast_err,
    output logic [2:0]        votes_cast,
    output logic              tx_valid,
    output logic [CODE_W-1:0] tx_code,
    output logic [1:0]        tx_judge,
    output logic              tx_last,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam int unsigned IdW  = 2;
    localparam int unsigned CntW = 3;
    localparam logic [CODE_W-1:0] CodeInvalid = CODE_W'(3);

    typedef enum logic [1:0] {StCollect, StSend, StDone} state_e;

    state_e                             state_q, state_d;
    logic [NUM_JUDGES-1:0]              voted_q, voted_d;
    logic [NUM_JUDGES-1:0][CODE_W-1:0]  codes_q, codes_d;
    logic [CntW-1:0]                    cnt_q, cnt_d;
    logic                               ack_q, ack_d;
    logic                               err_q, err_d;
    logic                               tx_valid_q, tx_valid_d;
    logic [CODE_W-1:0]                  tx_code_q, tx_code_d;
    logic [IdW-1:0]                     tx_judge_q, tx_judge_d;
    logic                               tx_last_q, tx_last_d;
    logic                               busy_q, busy_d;
    logic                               done_q, done_d;
    logic [IdW-1:0]                     nxt_id;

    // Lowest voted judge with ID >= lo.
    function automatic logic [IdW-1:0] first_voted(input logic [NUM_JUDGES-1:0] mask,
                                                   input int lo);
        logic [IdW-1:0] id;
        id = '0;
        for (int j = int'(NUM_JUDGES) - 1; j >= 0; j--) begin
            if (mask[j] && (j >= lo)) id = IdW'(j);
        end
        return id;
    endfunction

    // True when some voted judge has an ID strictly above idx.
    function automatic logic voted_above(input logic [NUM_JUDGES-1:0] mask, input int idx);
        logic r;
        r = 1'b0;
        for (int j = 0; j < int'(NUM_JUDGES); j++) begin
            if (mask[j] && (j > idx)) r = 1'b1;
        end
        return r;
    endfunction

    // Next-state: cast evaluation, poll termination and transfer sequencing.
    always_comb begin
        state_d    = state_q;
        voted_d    = voted_q;
        codes_d    = codes_q;
        cnt_d      = cnt_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        tx_valid_d = tx_valid_q;
        tx_code_d  = tx_code_q;
        tx_judge_d = tx_judge_q;
        tx_last_d  = tx_last_q;
        nxt_id     = '0;
        unique case (state_q)
            StCollect: begin
                if (judge_cast) begin
                    if ((judge_vote != CodeInvalid) && !voted_q[judge_id]) begin
                        voted_d[judge_id] = 1'b1;
                        codes_d[judge_id] = judge_vote;
                        cnt_d             = cnt_q + CntW'(1);
                        ack_d             = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                // The transition sees the count after this cycle's cast.
                if ((cnt_d == CntW'(NUM_JUDGES)) || (close_poll && (cnt_d != '0))) begin
                    state_d    = StSend;
                    nxt_id     = first_voted(voted_d, 0);
                    tx_valid_d = 1'b1;
                    tx_judge_d = nxt_id;
                    tx_code_d  = codes_d[nxt_id];
                    tx_last_d  = !voted_above(voted_d, int'(nxt_id));
                end else if (close_poll) begin
                    state_d = StDone;
                end
            end
            StSend: begin
                err_d = judge_cast;
                if (tx_ready) begin
                    if (tx_last_q) begin
                        state_d    = StDone;
                        tx_valid_d = 1'b0;
                        tx_code_d  = '0;
                        tx_judge_d = '0;
                        tx_last_d  = 1'b0;
                    end else begin
                        nxt_id     = first_voted(voted_q, int'(tx_judge_q) + 1);
                        tx_judge_d = nxt_id;
                        tx_code_d  = codes_q[nxt_id];
                        tx_last_d  = !voted_above(voted_q, int'(nxt_id));
                    end
                end
            end
            StDone: begin
                err_d   = judge_cast;
                voted_d = '0;
                codes_d = '0;
                cnt_d   = '0;
                state_d = StCollect;
            end
            default: state_d = StCollect;
        endcase
        busy_d = (state_d == StSend);
        done_d = (state_d == StDone);
    end

    // State and registered outputs; reset also drops tx_valid asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StCollect;
            voted_q    <= '0;
            codes_q    <= '0;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_code_q  <= '0;
            tx_judge_q <= '0;
            tx_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            voted_q    <= voted_d;
            codes_q    <= codes_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            tx_valid_q <= tx_valid_d;
            tx_code_q  <= tx_code_d;
            tx_judge_q <= tx_judge_d;
            tx_last_q  <= tx_last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign cast_ack   = ack_q;
    assign cast_err   = err_q;
    assign votes_cast = cnt_q;
    assign tx_valid   = tx_valid_q;
    assign tx_code    = tx_code_q;
    assign tx_judge   = tx_judge_q;
    assign tx_last    = tx_last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_ballot_sender.sv
// tb_ballot_sender: directed plus randomized polls checked against a
// transaction-level model (per-judge vote table and expected tx stream).
module tb_ballot_sender;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       judge_cast = 1'b0;
    logic [1:0] judge_id = '0;
    logic [1:0] judge_vote = '0;
    logic       close_poll = 1'b0;
    logic       cast_ack, cast_err;
    logic [2:0] votes_cast;
    logic       tx_valid;
    logic [1:0] tx_code;
    logic [1:0] tx_judge;
    logic       tx_last;
    logic       tx_ready = 1'b0;
    logic       busy, done;

    int n_checks = 0;
    int n_errors = 0;

    // Model: which judges have voted, their codes, and the accepted count.
    bit m_voted [4];
    int m_code  [4];
    int m_cnt;

    ballot_sender #(.NUM_JUDGES(4), .CODE_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .judge_cast (judge_cast),
        .judge_id   (judge_id),
        .judge_vote (judge_vote),
        .close_poll (close_poll),
        .cast_ack   (cast_ack),
        .cast_err   (cast_err),
        .votes_cast (votes_cast),
        .tx_valid   (tx_valid),
        .tx_code    (tx_code),
        .tx_judge   (tx_judge),
        .tx_last    (tx_last),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int j = 0; j < 4; j++) begin
            m_voted[j] = 1'b0;
            m_code[j]  = 0;
        end
        m_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        judge_cast = 1'b0;
        close_poll = 1'b0;
        tx_ready   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    // One COLLECT cycle: optional cast and/or close_poll, checked after the edge.
    task automatic do_cast(input bit cast, input int id, input int vote, input bit close,
                           output bit to_send, output bit ended);
        bit exp_ack, exp_err;
        @(negedge clk);
        judge_cast = cast;
        judge_id   = 2'(id);
        judge_vote = 2'(vote);
        close_poll = close;
        @(posedge clk);
        #1;
        judge_cast = 1'b0;
        close_poll = 1'b0;
        exp_ack = 1'b0;
        exp_err = 1'b0;
        if (cast) begin
            if (vote != 3 && !m_voted[id]) begin
                m_voted[id] = 1'b1;
                m_code[id]  = vote;
                m_cnt++;
                exp_ack = 1'b1;
            end else begin
                exp_err = 1'b1;
            end
        end
        check_eq("cast_ack", cast_ack, exp_ack);
        check_eq("cast_err", cast_err, exp_err);
        check_eq("votes_cast", votes_cast, m_cnt);
        to_send = (m_cnt == 4) || (close && m_cnt > 0);
        ended   = to_send || close;
        if (to_send) begin
            check_eq("send_busy", busy, 1);
            check_eq("send_valid", tx_valid, 1);
        end else if (close) begin
            check_eq("empty_done", done, 1);
            check_eq("empty_valid", tx_valid, 0);
            check_eq("empty_busy", busy, 0);
            @(posedge clk);
            #1;
            model_clear();
            check_eq("empty_done_end", done, 0);
            check_eq("empty_cnt_clr", votes_cast, 0);
        end
    endtask

    // Drain the SEND phase. mode 0: ready high, 1: random ready, 2: 5 stalls then toggle.
    task automatic recv(input int mode, input bit cast_in_send);
        int q_j[$];
        int q_c[$];
        int k = 0;
        int cyc = 0;
        bit r;
        bit sent;
        for (int j = 0; j < 4; j++) begin
            if (m_voted[j]) begin
                q_j.push_back(j);
                q_c.push_back(m_code[j]);
            end
        end
        while (k < q_j.size() && cyc < 200) begin
            check_eq("tx_valid", tx_valid, 1);
            check_eq("busy", busy, 1);
            check_eq("tx_judge", tx_judge, q_j[k]);
            check_eq("tx_code", tx_code, q_c[k]);
            check_eq("tx_last", tx_last, (k == q_j.size() - 1) ? 1 : 0);
            @(negedge clk);
            case (mode)
                0:       r = 1'b1;
                1:       r = 1'($urandom_range(0, 1));
                default: r = (cyc >= 5) && (cyc % 2 == 1);
            endcase
            sent = cast_in_send && (cyc == 1);
            tx_ready   = r;
            judge_cast = sent;
            judge_id   = 2'($urandom_range(0, 3));
            judge_vote = 2'd0;
            @(posedge clk);
            #1;
            judge_cast = 1'b0;
            if (sent) begin
                check_eq("send_cast_err", cast_err, 1);
                check_eq("send_cast_ack", cast_ack, 0);
            end
            if (r) k++;
            cyc++;
        end
        check_eq("stream_complete", k, q_j.size());
        check_eq("done_pulse", done, 1);
        check_eq("done_valid", tx_valid, 0);
        check_eq("done_busy", busy, 0);
        @(negedge clk);
        tx_ready = 1'b0;
        @(posedge clk);
        #1;
        model_clear();
        check_eq("done_end", done, 0);
        check_eq("cnt_clr", votes_cast, 0);
        check_eq("collect_busy", busy, 0);
    endtask

    initial begin
        bit ts, en;
        do_reset();
        #1;
        check_eq("rst_valid", tx_valid, 0);
        check_eq("rst_last", tx_last, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_ack", cast_ack, 0);
        check_eq("rst_err", cast_err, 0);
        check_eq("rst_code", tx_code, 0);
        check_eq("rst_judge", tx_judge, 0);
        check_eq("rst_cnt", votes_cast, 0);

        // Full poll, ready held high.
        do_cast(1, 0, 0, 0, ts, en);
        do_cast(1, 1, 1, 0, ts, en);
        do_cast(1, 2, 2, 0, ts, en);
        do_cast(1, 3, 0, 0, ts, en);
        check_eq("full_to_send", ts, 1);
        if (ts) recv(0, 0);

        // Repeat judge and invalid code rejected; early close sends one vote.
        do_cast(1, 1, 2, 0, ts, en);
        do_cast(1, 1, 0, 0, ts, en);
        do_cast(1, 2, 3, 0, ts, en);
        do_cast(0, 0, 0, 1, ts, en);
        check_eq("single_to_send", ts, 1);
        if (ts) recv(0, 0);

        // Close with no votes.
        do_cast(0, 0, 0, 1, ts, en);
        check_eq("empty_no_send", ts, 0);

        // Stalled transfer.
        do_cast(1, 2, 1, 0, ts, en);
        do_cast(1, 0, 2, 0, ts, en);
        do_cast(1, 3, 1, 0, ts, en);
        do_cast(1, 1, 0, 0, ts, en);
        if (ts) recv(2, 0);

        // Cast coincident with close; cast during SEND.
        do_cast(1, 0, 1, 0, ts, en);
        do_cast(1, 3, 2, 1, ts, en);
        check_eq("coinc_to_send", ts, 1);
        if (ts) recv(0, 1);

        // Reset during the second transfer.
        do_cast(1, 0, 0, 0, ts, en);
        do_cast(1, 1, 1, 0, ts, en);
        do_cast(1, 2, 2, 0, ts, en);
        do_cast(1, 3, 1, 0, ts, en);
        @(negedge clk);
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_mid_judge", tx_judge, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_valid", tx_valid, 0);
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_cnt", votes_cast, 0);
        tx_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        do_cast(1, 2, 0, 1, ts, en);
        check_eq("post_rst_send", ts, 1);
        if (ts) recv(1, 0);

        // Randomized polls.
        for (int p = 0; p < 40; p++) begin
            for (int s = 0; s < 12; s++) begin
                if ($urandom_range(0, 3) == 0) do_cast(0, 0, 0, 0, ts, en);
                do_cast(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        ($urandom_range(0, 5) == 0) || (s == 11), ts, en);
                if (ts) recv(1, 1'($urandom_range(0, 1)));
                if (en) break;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
